// File: rtl/alu_mul_sequencer_if.sv
// Handshake and ALU-borrowing bus between the pipeline and the shift-add MUL sequencer.
// The slave side is the sequencer; the master side is the pipeline plus the shared ALU.
interface alu_mul_sequencer_if #(
   parameter int WIDTH = 64
);
   logic             start;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] product;
   logic             stall;
   logic [WIDTH-1:0] alu_A;
   logic [WIDTH-1:0] alu_B;
   logic [2:0]       alu_cntrl;
   logic [WIDTH-1:0] alu_result;

   modport slave (
      input  start, op_a, op_b, alu_result,
      output busy, done, product, stall, alu_A, alu_B, alu_cntrl
   );

   modport master (
      output start, op_a, op_b, alu_result,
      input  busy, done, product, stall, alu_A, alu_B, alu_cntrl
   );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier that borrows the shared ALU adder, one partial product per cycle.
// state | meaning
// IDLE  | ALU released; waiting for start
// RUN   | one add-and-shift per cycle on the shared ALU, pipeline stalled
// DONE  | product valid, one-cycle done pulse
module alu_mul_sequencer #(
   parameter int WIDTH = 64,
   parameter int CNT_W = 7
) (
   input  logic               clk,
   input  logic               reset,
   alu_mul_sequencer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [2:0] ALU_ADD  = 3'b010;
   localparam logic [2:0] ALU_IDLE = 3'b000;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] acc, m, q, product;
   logic [CNT_W-1:0] count;
   logic             last;

   // Stop early once no multiplier bits remain, or after the final bit position.
   assign last = ((q >> 1) == '0) || (count == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         acc     <= '0;
         m       <= '0;
         q       <= '0;
         count   <= '0;
         product <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  m     <= bus.op_a;
                  q     <= bus.op_b;
                  acc   <= '0;
                  count <= '0;
               end
            end
            RUN: begin
               acc   <= bus.alu_result;
               m     <= m << 1;
               q     <= q >> 1;
               count <= count + CNT_W'(1);
               if (last) product <= bus.alu_result;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt     = state;
      bus.alu_A     = '0;
      bus.alu_B     = '0;
      bus.alu_cntrl = ALU_IDLE;
      case (state)
         IDLE: if (bus.start) state_nxt = RUN;
         RUN: begin
            bus.alu_A     = acc;
            bus.alu_B     = q[0] ? m : '0;
            bus.alu_cntrl = ALU_ADD;
            if (last) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.busy    = (state == RUN);
   assign bus.done    = (state == DONE);
   assign bus.product = product;
   // Freeze the issuing instruction from its start cycle through the done cycle.
   assign bus.stall   = (state == RUN) || ((state == IDLE) && bus.start) || (state == DONE);
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a behavioural shared ALU.
module tb_alu_mul_sequencer;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;
   logic [63:0] bseq [0:127];

   alu_mul_sequencer_if #(.WIDTH(64)) bus ();

   alu_mul_sequencer #(.WIDTH(64), .CNT_W(7)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   assign bus.alu_result = (bus.alu_cntrl == 3'b010) ? (bus.alu_A + bus.alu_B) : 64'd0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 of the cycle after the post-done IDLE cycle.
   task automatic run_mul(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] p, input int k);
      int nbusy, nstall, dcyc, bad;
      nbusy = 0; nstall = 0; dcyc = -1; bad = 0;
      bus.op_a  = a;
      bus.op_b  = b;
      bus.start = 1'b1;
      @(negedge clk);
      if (bus.stall) nstall++;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.op_a  = ~a;
      bus.op_b  = ~b;
      for (int c = 1; c < 200; c++) begin
         @(negedge clk);
         if (bus.busy) begin
            bseq[nbusy[6:0]] = bus.alu_B;
            nbusy++;
            if (bus.alu_cntrl != 3'b010) bad++;
         end else if (bus.alu_cntrl != 3'b000) bad++;
         if (bus.stall) nstall++;
         if (bus.done) begin
            dcyc = c;
            chk({tag, " product"}, bus.product, p);
            break;
         end
         @(posedge clk); #1;
      end
      if (dcyc < 0) chk({tag, " timeout"}, 64'd0, 64'd1);
      chk({tag, " done_cycle"}, 64'(dcyc), 64'(k + 1));
      chk({tag, " busy_cycles"}, 64'(nbusy), 64'(k));
      chk({tag, " stall_cycles"}, 64'(nstall), 64'(k + 2));
      chk({tag, " alu_cntrl"}, 64'(bad), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, " done_low"}, 64'(bus.done), 64'd0);
      chk({tag, " held"}, bus.product, p);
      @(posedge clk); #1;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.op_a  = '0;
      bus.op_b  = '0;
      @(posedge clk);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst busy", 64'(bus.busy), 64'd0);
      chk("rst done", 64'(bus.done), 64'd0);
      chk("rst product", bus.product, 64'd0);
      chk("rst stall", 64'(bus.stall), 64'd0);
      chk("rst alu_cntrl", 64'(bus.alu_cntrl), 64'd0);
      @(posedge clk); #1;

      run_mul("3x5", 64'd3, 64'd5, 64'd15, 3);
      chk("3x5 aluB0", bseq[0], 64'd3);
      chk("3x5 aluB1", bseq[1], 64'd0);
      chk("3x5 aluB2", bseq[2], 64'd12);

      run_mul("1234x0", 64'h1234, 64'd0, 64'd0, 1);
      run_mul("neg1x2", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 2);
      run_mul("3xmsb", 64'd3, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64);

      // 7*9 with start held: k=4, done in cycle 5, 2*2 accepted at edge 6, done in cycle 9.
      begin
         int ndone;
         ndone = 0;
         bus.op_a  = 64'd7;
         bus.op_b  = 64'd9;
         bus.start = 1'b1;
         @(posedge clk); #1;
         bus.op_a = 64'd2;
         bus.op_b = 64'd2;
         for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus.done) ndone++;
            if (c == 5) begin
               chk("hold done5", 64'(bus.done), 64'd1);
               chk("hold prod63", bus.product, 64'd63);
            end
            if (c == 6) begin
               chk("hold idle busy", 64'(bus.busy), 64'd0);
               chk("hold idle stall", 64'(bus.stall), 64'd1);
            end
            if (c == 8) begin
               chk("hold run2 busy", 64'(bus.busy), 64'd1);
               chk("hold prod kept", bus.product, 64'd63);
            end
            if (c == 9) begin
               chk("hold done9", 64'(bus.done), 64'd1);
               chk("hold prod4", bus.product, 64'd4);
            end
            @(posedge clk); #1;
            if (c == 6) bus.start = 1'b0;
         end
         chk("hold done_count", 64'(ndone), 64'd2);
      end

      // Reset in the second RUN cycle of 6*7.
      bus.op_a  = 64'd6;
      bus.op_b  = 64'd7;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #2;
      chk("abort pre busy", 64'(bus.busy), 64'd1);
      reset = 1'b1;
      #1;
      chk("abort busy", 64'(bus.busy), 64'd0);
      chk("abort done", 64'(bus.done), 64'd0);
      chk("abort product", bus.product, 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("abort no_done", 64'(bus.done), 64'd0);
      @(posedge clk); #1;
      run_mul("6x7", 64'd6, 64'd7, 64'd42, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
